mult_execute_unit: RTL and testbench

- Multiply functional unit: the consumer end of the multiply reservation station's issue interface.
- Accepts one issued RV32M multiply (MUL/MULH/MULHSU/MULHU) with its operand values.
- Computes the product iteratively and holds the result until the CDB arbiter grants the broadcast.
- Sits between the mult reservation station / register-read stage and the CDB arbiter; its ready output is the station's issue_mult input.

---
 rtl/mult_execute_unit.sv | 123 ++++++++++++
 tb/tb_mult_execute_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_execute_unit.sv
// Iterative RV32M multiply unit: accepts one op, shift-adds STEPS_PER_CYCLE bits per cycle, result
// on the CDB 32/STEPS_PER_CYCLE cycles after accept; holds result stable (op_ready low) until cdb_grant.
module mult_execute_unit #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter int ROB_IDX_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op_funct3,
  input  logic [31:0]          op_rs1,
  input  logic [31:0]          op_rs2,
  input  logic [5:0]           op_pd,
  input  logic [ROB_IDX_W-1:0] op_rob_idx,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [31:0]          cdb_result,
  output logic [5:0]           cdb_pd,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx
);

  localparam int N = 32 / STEPS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [5:0]           pd;
    logic [ROB_IDX_W-1:0] rob_idx;
  } tag_t;

  state_t      state;
  tag_t        tag;
  logic [2:0]  funct3;
  logic        sa, sb;
  logic [5:0]  cnt;
  logic [63:0] acc, mcand;
  logic [31:0] mplier;

  logic        sa_in, sb_in;
  logic [63:0] acc_nxt, mcand_nxt, prod;
  logic [31:0] res_sel;

  assign op_ready = (state == IDLE);
  assign cdb_req  = (state == DONE);

  assign sa_in = op_rs1[31] && ((op_funct3 == 3'b001) || (op_funct3 == 3'b010));
  assign sb_in = op_rs2[31] && (op_funct3 == 3'b001);

  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (mplier[i]) acc_nxt = acc_nxt + mcand_nxt;
      mcand_nxt = mcand_nxt << 1;
    end
  end

  // Signs were stripped on accept; restore them on the full 64-bit product.
  assign prod = (sa ^ sb) ? (~acc_nxt + 64'd1) : acc_nxt;

  always_comb begin
    res_sel = 32'h0;
    if (!funct3[2]) res_sel = (funct3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= IDLE;
      tag         <= '0;
      funct3      <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cdb_result  <= '0;
      cdb_pd      <= '0;
      cdb_rob_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            funct3  <= op_funct3;
            tag.pd  <= op_pd;
            tag.rob_idx <= op_rob_idx;
            sa      <= sa_in;
            sb      <= sb_in;
            mcand   <= {32'h0, sa_in ? (~op_rs1 + 32'd1) : op_rs1};
            mplier  <= sb_in ? (~op_rs2 + 32'd1) : op_rs2;
            acc     <= '0;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier >> STEPS_PER_CYCLE;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(N - 1)) begin
            cdb_result  <= res_sel;
            cdb_pd      <= tag.pd;
            cdb_rob_idx <= tag.rob_idx;
            state       <= DONE;
          end
        end
        DONE: begin
          if (cdb_grant) begin
            cdb_result  <= '0;
            cdb_pd      <= '0;
            cdb_rob_idx <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_execute_unit.sv
// Directed vector bench for mult_execute_unit (1 and 4 bits per cycle).
module tb_mult_execute_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, op_valid, cdb_grant;
  logic [2:0]  op_funct3;
  logic [31:0] op_rs1, op_rs2;
  logic [5:0]  op_pd;
  logic [3:0]  op_rob_idx;
  logic        op_ready, cdb_req;
  logic [31:0] cdb_result;
  logic [5:0]  cdb_pd;
  logic [3:0]  cdb_rob_idx;

  logic        v4, g4, r4, q4;
  logic [31:0] res4;
  logic [5:0]  pd4;
  logic [3:0]  rob4;

  mult_execute_unit #(.STEPS_PER_CYCLE(1), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_funct3(op_funct3),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_pd(op_pd), .op_rob_idx(op_rob_idx),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_result(cdb_result),
    .cdb_pd(cdb_pd), .cdb_rob_idx(cdb_rob_idx)
  );

  mult_execute_unit #(.STEPS_PER_CYCLE(4), .ROB_IDX_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(v4), .op_ready(r4), .op_funct3(op_funct3),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_pd(op_pd), .op_rob_idx(op_rob_idx),
    .cdb_req(q4), .cdb_grant(g4), .cdb_result(res4),
    .cdb_pd(pd4), .cdb_rob_idx(rob4)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  pd;
    logic [3:0]  rob;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] pd, input logic [3:0] rob);
    op_funct3 = f; op_rs1 = a; op_rs2 = b; op_pd = pd; op_rob_idx = rob;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int lat);
    lat = 0;
    while (!cdb_req && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic grant_and_check(input string tag);
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    check({tag, "_req_low"}, cdb_req, 0);
    check({tag, "_ready"}, op_ready, 1);
    check({tag, "_cleared"}, {cdb_result, cdb_pd, cdb_rob_idx}, 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit ok;
    ok = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (cdb_req || !op_ready) ok = 1'b0;
    end
    check({tag, "_no_broadcast"}, ok, 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    issue(v.f, v.a, v.b, v.pd, v.rob);
    check({tag, "_ready_drop"}, op_ready, 0);
    wait_req(100, lat);
    check({tag, "_latency"}, lat, 32);
    check({tag, "_result"}, cdb_result, v.exp);
    check({tag, "_pd"}, cdb_pd, v.pd);
    check({tag, "_rob"}, cdb_rob_idx, v.rob);
    grant_and_check(tag);
  endtask

  initial begin
    int lat;
    bit ok;

    vecs[0]  = '{3'b000, 32'h00000007, 32'h00000006, 6'd5,  4'd3,  32'h0000002A};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 6'd1,  4'd1,  32'h40000000};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  4'd2,  32'h00000000};
    vecs[3]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 6'd3,  4'd4,  32'hFFFFFFFE};
    vecs[4]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd4,  4'd5,  32'hFFFFFFFE};
    vecs[5]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd63, 4'd15, 32'hFFFFFFFF};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h00000001, 6'd7,  4'd6,  32'hFFFFFFFF};
    vecs[7]  = '{3'b000, 32'h00000003, 32'h00000000, 6'd0,  4'd0,  32'h00000000};
    vecs[8]  = '{3'b011, 32'h80000000, 32'h00000002, 6'd9,  4'd8,  32'h00000001};
    vecs[9]  = '{3'b010, 32'h00000002, 32'hFFFFFFFF, 6'd10, 4'd9,  32'h00000001};
    vecs[10] = '{3'b100, 32'h00000005, 32'h00000005, 6'd11, 4'd10, 32'h00000000};

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; cdb_grant = 1'b0; v4 = 1'b0; g4 = 1'b0;
    op_funct3 = '0; op_rs1 = '0; op_rs2 = '0; op_pd = '0; op_rob_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", op_ready, 1);
    check("reset_req", cdb_req, 0);
    check("reset_outputs", {cdb_result, cdb_pd, cdb_rob_idx}, 0);
    check("reset_dut4", {r4, q4, res4, pd4, rob4}, {1'b1, 43'h0});

    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held while the arbiter withholds grant.
    issue(3'b000, 32'h12345678, 32'h00000003, 6'd9, 4'd7);
    wait_req(100, lat);
    check("bp_latency", lat, 32);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op_valid = i[0];
      op_rs1 = $urandom;
      @(negedge clk);
      if (!(cdb_req && !op_ready && cdb_result == 32'h369D0368 && cdb_pd == 6'd9 && cdb_rob_idx == 4'd7))
        ok = 1'b0;
    end
    op_valid = 1'b0;
    check("bp_stable", ok, 1);
    grant_and_check("bp");
    quiet("bp_stray", 40);

    // Flush partway through BUSY.
    issue(3'b000, 32'h00000007, 32'h00000006, 6'd5, 4'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_idle", {op_ready, cdb_req}, 2'b10);
    check("flush_busy_outputs", {cdb_result, cdb_pd, cdb_rob_idx}, 0);
    quiet("flush_busy", 40);
    run_vec("after_flush_busy", vecs[1]);

    // Flush wins over a same-cycle grant in DONE.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd12, 4'd12);
    wait_req(100, lat);
    check("flush_done_reached", cdb_req, 1);
    flush = 1'b1; cdb_grant = 1'b1;
    @(negedge clk);
    flush = 1'b0; cdb_grant = 1'b0;
    check("flush_done_idle", {op_ready, cdb_req}, 2'b10);
    check("flush_done_outputs", {cdb_result, cdb_pd, cdb_rob_idx}, 0);
    quiet("flush_done", 40);
    run_vec("after_flush_done", vecs[4]);

    // Reset mid-BUSY.
    issue(3'b000, 32'h00000007, 32'h00000006, 6'd5, 4'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy_idle", {op_ready, cdb_req}, 2'b10);
    quiet("rst_busy", 40);

    // Flush coincident with op_valid in IDLE: op must be dropped.
    op_funct3 = 3'b000; op_rs1 = 32'd9; op_rs2 = 32'd9; op_pd = 6'd1; op_rob_idx = 4'd1;
    op_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", op_ready, 1);
    quiet("flush_idle", 40);

    // Four bits per cycle: 8-cycle latency.
    op_funct3 = 3'b000; op_rs1 = 32'd7; op_rs2 = 32'd6; op_pd = 6'd5; op_rob_idx = 4'd3;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    check("s4_ready_drop", r4, 0);
    lat = 0;
    while (!q4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("s4_latency", lat, 8);
    check("s4_result", res4, 32'h0000002A);
    check("s4_tags", {pd4, rob4}, {6'd5, 4'd3});
    g4 = 1'b1;
    @(negedge clk);
    g4 = 1'b0;
    check("s4_after_grant", {r4, q4, res4}, {1'b1, 1'b0, 32'h0});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
